// File: rtl/rom_sram_ctrl_pkg.sv
// Shared definitions for the base-SRAM controller: FSM states, aluop codes, enable levels.
`default_nettype none

package rom_sram_ctrl_pkg;

  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic WRITE_ENABLE = 1'b1;

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic [2:0] {
    SRAM_IDLE     = 3'd0,
    SRAM_WR_SETUP = 3'd1,
    SRAM_WR_PULSE = 3'd2,
    SRAM_WR_HOLD  = 3'd3,
    SRAM_WR_DONE  = 3'd4
  } sram_state_t;

endpackage

`default_nettype wire

// File: rtl/rom_sram_ctrl_byte_lane_unit.sv
// Combinational byte-lane logic: store alignment (be_n, replicated data) and load extraction.
`default_nettype none

module byte_lane_unit
  import rom_sram_ctrl_pkg::*;
(
  input  logic [7:0]  aluop,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  store_be_n,
  output logic [31:0] store_word,
  output logic [31:0] load_data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    store_be_n = 4'b0000;
    store_word = store_data;
    case (aluop)
      EXE_SB_OP: begin
        store_be_n = ~(4'b0001 << addr_lo);
        store_word = {4{store_data[7:0]}};
      end
      EXE_SH_OP: begin
        store_be_n = addr_lo[1] ? 4'b0011 : 4'b1100;
        store_word = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (addr_lo)
      2'd0:    sel_byte = load_word[7:0];
      2'd1:    sel_byte = load_word[15:8];
      2'd2:    sel_byte = load_word[23:16];
      default: sel_byte = load_word[31:24];
    endcase
    sel_half = addr_lo[1] ? load_word[31:16] : load_word[15:0];

    case (aluop)
      EXE_LB_OP:  load_data = {{24{sel_byte[7]}}, sel_byte};
      EXE_LBU_OP: load_data = {24'h0, sel_byte};
      EXE_LH_OP:  load_data = {{16{sel_half[15]}}, sel_half};
      EXE_LHU_OP: load_data = {16'h0, sel_half};
      default:    load_data = load_word;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/rom_sram_ctrl.sv
// Shared instruction/data SRAM controller: zero-latency reads, sequenced multi-cycle writes with stall.
`default_nettype none

module rom_sram_ctrl
  import rom_sram_ctrl_pkg::*;
#(
  parameter int ADDR_W    = 20,
  parameter int WE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_i,
  input  logic              we_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  input  logic [7:0]        aluop_i,
  output logic [31:0]       inst_o,
  output logic [31:0]       mem_rdata_o,
  output logic              stallreq_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [31:0]       sram_wdata_o,
  input  logic [31:0]       sram_rdata_i,
  output logic              sram_data_oe_o,
  output logic [3:0]        sram_be_n_o,
  output logic              sram_ce_n_o,
  output logic              sram_oe_n_o,
  output logic              sram_we_n_o
);

  localparam int CNT_W = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;

  sram_state_t       state, state_nxt;
  logic [CNT_W-1:0]  we_cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;
  logic [3:0]        lat_be_n;

  logic [3:0]        align_be_n;
  logic [31:0]       align_wdata;
  logic [31:0]       load_data;
  logic              wr_start;
  logic              rd_active;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{addr_i[31:ADDR_W+2]};

  byte_lane_unit u_lane (
    .aluop      (aluop_i),
    .addr_lo    (addr_i[1:0]),
    .store_data (wdata_i),
    .load_word  (sram_rdata_i),
    .store_be_n (align_be_n),
    .store_word (align_wdata),
    .load_data  (load_data)
  );

  assign wr_start = (state == SRAM_IDLE) && (ce_i == CHIP_ENABLE) && (we_i == WRITE_ENABLE);

  // WR_DONE reads regardless of we_i: the PC still shows the finished store for one cycle.
  assign rd_active = !rst && (ce_i == CHIP_ENABLE) &&
                     (((state == SRAM_IDLE) && (we_i != WRITE_ENABLE)) || (state == SRAM_WR_DONE));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SRAM_IDLE;
      we_cnt    <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be_n  <= 4'hF;
    end else begin
      state <= state_nxt;
      if (state == SRAM_WR_PULSE) we_cnt <= we_cnt + 1'b1;
      else                        we_cnt <= '0;
      if (wr_start) begin
        lat_addr  <= addr_i[ADDR_W+1:2];
        lat_wdata <= align_wdata;
        lat_be_n  <= align_be_n;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SRAM_IDLE:     if (wr_start) state_nxt = SRAM_WR_SETUP;
      SRAM_WR_SETUP: state_nxt = SRAM_WR_PULSE;
      SRAM_WR_PULSE: if (we_cnt == CNT_W'(WE_CYCLES - 1)) state_nxt = SRAM_WR_HOLD;
      SRAM_WR_HOLD:  state_nxt = SRAM_WR_DONE;
      SRAM_WR_DONE:  state_nxt = SRAM_IDLE;
      default:       state_nxt = SRAM_IDLE;
    endcase
  end

  always_comb begin
    sram_ce_n_o    = 1'b1;
    sram_oe_n_o    = 1'b1;
    sram_we_n_o    = 1'b1;
    sram_be_n_o    = 4'hF;
    sram_data_oe_o = 1'b0;
    sram_addr_o    = addr_i[ADDR_W+1:2];
    sram_wdata_o   = lat_wdata;
    stallreq_o     = 1'b0;
    inst_o         = 32'h0;
    mem_rdata_o    = 32'h0;

    if (rd_active) begin
      sram_ce_n_o = 1'b0;
      sram_oe_n_o = 1'b0;
      sram_be_n_o = 4'h0;
      inst_o      = sram_rdata_i;
      mem_rdata_o = load_data;
    end else if (!rst) begin
      case (state)
        SRAM_IDLE: stallreq_o = wr_start;
        SRAM_WR_SETUP, SRAM_WR_PULSE, SRAM_WR_HOLD: begin
          sram_ce_n_o    = 1'b0;
          sram_data_oe_o = 1'b1;
          sram_addr_o    = lat_addr;
          sram_be_n_o    = lat_be_n;
          sram_we_n_o    = (state != SRAM_WR_PULSE);
          stallreq_o     = (state != SRAM_WR_HOLD);
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rom_sram_ctrl.sv
// Self-checking bench: directed cases plus random loads/stores against a byte-level memory model.
`default_nettype none
`timescale 1ns/1ps

module tb_rom_sram_ctrl;
  import rom_sram_ctrl_pkg::*;

  localparam int ADDR_W    = 20;
  localparam int WE_CYCLES = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              ce_i, we_i;
  logic [31:0]       addr_i, wdata_i;
  logic [7:0]        aluop_i;
  logic [31:0]       inst_o, mem_rdata_o, sram_wdata_o, sram_rdata_i;
  logic              stallreq_o, sram_data_oe_o, sram_ce_n_o, sram_oe_n_o, sram_we_n_o;
  logic [ADDR_W-1:0] sram_addr_o;
  logic [3:0]        sram_be_n_o;

  int n_tests = 0;
  int n_fail  = 0;
  int pulse_cnt = 0;
  logic prev_we_n = 1'b1;

  logic        use_fixed = 1'b1;
  logic [31:0] fixed_rdata = 32'h0;
  logic [31:0] model_mem [0:255];
  logic [31:0] ref_mem   [0:255];

  always #5 clk = ~clk;

  rom_sram_ctrl #(.ADDR_W(ADDR_W), .WE_CYCLES(WE_CYCLES)) dut (
    .clk(clk), .rst(rst), .ce_i(ce_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .aluop_i(aluop_i), .inst_o(inst_o), .mem_rdata_o(mem_rdata_o), .stallreq_o(stallreq_o),
    .sram_addr_o(sram_addr_o), .sram_wdata_o(sram_wdata_o), .sram_rdata_i(sram_rdata_i),
    .sram_data_oe_o(sram_data_oe_o), .sram_be_n_o(sram_be_n_o), .sram_ce_n_o(sram_ce_n_o),
    .sram_oe_n_o(sram_oe_n_o), .sram_we_n_o(sram_we_n_o)
  );

  assign sram_rdata_i = use_fixed ? fixed_rdata : model_mem[sram_addr_o[7:0]];

  // SRAM device model plus we_n pulse counter, evaluated mid-cycle
  always @(negedge clk) begin
    if (!sram_ce_n_o && !sram_we_n_o && sram_data_oe_o)
      for (int k = 0; k < 4; k++)
        if (!sram_be_n_o[k]) model_mem[sram_addr_o[7:0]][8*k +: 8] <= sram_wdata_o[8*k +: 8];
    if (!prev_we_n && sram_we_n_o) pulse_cnt++;
    prev_we_n = sram_we_n_o;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] a, input logic [7:0] op);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'((w >> (8 * a)) & 32'hFF);
    h = a[1] ? w[31:16] : w[15:0];
    if (op == EXE_LB_OP)       return {{24{b[7]}}, b};
    else if (op == EXE_LBU_OP) return {24'h0, b};
    else if (op == EXE_LH_OP)  return {{16{h[15]}}, h};
    else if (op == EXE_LHU_OP) return {16'h0, h};
    return w;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [1:0] a,
                                            input logic [31:0] d, input logic [7:0] op);
    logic [31:0] r;
    r = w;
    if (op == EXE_SB_OP)      r[8*a +: 8] = d[7:0];
    else if (op == EXE_SH_OP) r[16*a[1] +: 16] = d[15:0];
    else                      r = d;
    return r;
  endfunction

  function automatic logic [3:0] ref_be_n(input logic [1:0] a, input logic [7:0] op);
    if (op == EXE_SB_OP) return 4'hF & ~(4'(1) << a);
    if (op == EXE_SH_OP) return a[1] ? 4'b0011 : 4'b1100;
    return 4'h0;
  endfunction

  // Called just after a falling edge; returns just after the falling edge that begins the
  // cycle following WR_DONE.
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [7:0] op);
    int stall_cyc, low_cyc, p0;
    logic seen_stall;
    logic [31:0] exp_wd;
    ce_i = 1; we_i = 1; addr_i = a; wdata_i = d; aluop_i = op;
    p0 = pulse_cnt; stall_cyc = 0; low_cyc = 0; seen_stall = 0;
    exp_wd = (op == EXE_SB_OP) ? {4{d[7:0]}} : (op == EXE_SH_OP) ? {2{d[15:0]}} : d;
    for (int i = 0; i < 20; i++) begin
      #2;
      if (stallreq_o) begin stall_cyc++; seen_stall = 1; end
      if (!sram_we_n_o) begin
        low_cyc++;
        chk("st_addr", 32'(sram_addr_o), 32'(a[21:2]));
        chk("st_be_n", 32'(sram_be_n_o), 32'(ref_be_n(a[1:0], op)));
        chk("st_wdata", sram_wdata_o, exp_wd);
      end
      if (seen_stall && !stallreq_o) break;
      @(negedge clk);
    end
    chk("hold_we_oe", {30'h0, sram_we_n_o, sram_data_oe_o}, 32'h3);
    chk("stall_cycles", stall_cyc, 2 + WE_CYCLES);
    chk("we_low_cycles", low_cyc, WE_CYCLES);
    ref_mem[a[9:2]] = ref_store(ref_mem[a[9:2]], a[1:0], d, op);
    @(negedge clk);
    #2;
    chk("one_pulse", pulse_cnt - p0, 1);
    chk("done_oe", {31'h0, sram_data_oe_o}, 32'h0);
    if (!use_fixed && op == EXE_SW_OP) chk("done_read", mem_rdata_o, ref_mem[a[9:2]]);
    @(negedge clk);
  endtask

  task automatic do_load(input logic [31:0] a, input logic [7:0] op);
    ce_i = 1; we_i = 0; addr_i = a; aluop_i = op;
    #2;
    chk("ld_data", mem_rdata_o, ref_load(ref_mem[a[9:2]], a[1:0], op));
    chk("ld_inst", inst_o, ref_mem[a[9:2]]);
    chk("ld_oe_n", {31'h0, sram_oe_n_o}, 32'h0);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] a, d;
    logic [7:0]  op;
    int          sel;
    for (int i = 0; i < 256; i++) begin
      model_mem[i] = $urandom;
      ref_mem[i]   = model_mem[i];
    end
    rst = 1; ce_i = 1; we_i = 0; addr_i = 0; wdata_i = 0; aluop_i = EXE_LW_OP;

    repeat (2) @(negedge clk);
    #2;
    chk("rst_nctl", {28'h0, sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_data_oe_o}, 32'hE);
    chk("rst_be_n", 32'(sram_be_n_o), 32'hF);
    chk("rst_stall", {31'h0, stallreq_o}, 32'h0);
    @(negedge clk);
    rst = 0;

    fixed_rdata = 32'h24020005;
    addr_i = 32'h80000010;
    #2;
    chk("fetch_addr", 32'(sram_addr_o), 32'h00004);
    chk("fetch_oe_n", {31'h0, sram_oe_n_o}, 32'h0);
    chk("fetch_inst", inst_o, 32'h24020005);
    @(negedge clk);

    fixed_rdata = 32'h80FF7F01;
    addr_i = 32'h80000003; aluop_i = EXE_LB_OP;  #2; chk("lb", mem_rdata_o, 32'hFFFFFF80); @(negedge clk);
    aluop_i = EXE_LBU_OP; #2; chk("lbu", mem_rdata_o, 32'h00000080); @(negedge clk);
    addr_i = 32'h80000002; aluop_i = EXE_LH_OP; #2; chk("lh", mem_rdata_o, 32'hFFFF80FF); @(negedge clk);

    ce_i = 0; #2;
    chk("ce0_ctl", {29'h0, sram_ce_n_o, sram_oe_n_o, sram_we_n_o}, 32'h7);
    chk("ce0_out", inst_o | mem_rdata_o, 32'h0);
    @(negedge clk);

    use_fixed = 0;
    do_store(32'h00000001, 32'h000000AB, EXE_SB_OP);
    do_store(32'h00000100, 32'h11223344, EXE_SW_OP);
    do_store(32'h00000104, 32'h55667788, EXE_SW_OP);
    do_load(32'h00000100, EXE_LW_OP);
    do_load(32'h00000104, EXE_LW_OP);
    do_load(32'h00000000, EXE_LW_OP);

    // reset during the write pulse aborts the sequence
    ce_i = 1; we_i = 1; addr_i = 32'h00000208; wdata_i = 32'hCAFEF00D; aluop_i = EXE_SW_OP;
    begin
      logic hit;
      hit = 0;
      for (int i = 0; i < 10 && !hit; i++) begin
        #2;
        if (!sram_we_n_o) hit = 1; else @(negedge clk);
      end
      chk("pulse_seen", {31'h0, hit}, 32'h1);
    end
    ref_mem[8'h82] = 32'hCAFEF00D;
    rst = 1;
    @(negedge clk); #2;
    chk("abort_ctl", {29'h0, sram_we_n_o, sram_data_oe_o, stallreq_o}, 32'h4);
    rst = 0; ce_i = 0; we_i = 0;
    @(negedge clk); #2;
    chk("abort_idle", {30'h0, sram_data_oe_o, stallreq_o}, 32'h0);
    @(negedge clk);
    do_load(32'h00000208, EXE_LW_OP);

    for (int n = 0; n < 60; n++) begin
      a   = {22'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))};
      d   = $urandom;
      sel = $urandom_range(0, 8);
      case (sel)
        0: op = EXE_LB_OP;  1: op = EXE_LBU_OP; 2: op = EXE_LH_OP;
        3: op = EXE_LHU_OP; 4: op = EXE_LW_OP;  5: op = EXE_SB_OP;
        6: op = EXE_SH_OP;  default: op = EXE_SW_OP;
      endcase
      if (sel == 8 && n % 4 == 0) begin
        ce_i = 0; we_i = $urandom_range(0, 1); addr_i = a; #2;
        chk("rnd_idle", {29'h0, sram_ce_n_o, sram_we_n_o, stallreq_o} | 32'(inst_o != 0), 32'h6);
        @(negedge clk);
      end else if (sel >= 5) do_store(a, d, op);
      else do_load(a, op);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
